// File: rtl/read_data_checker_pkg.sv
// Shared definitions for the DDR3 memory-test read path: verdict encodings,
// checker state encoding and the test pattern. The command generator imports
// the same seed and expected_word() so writer and reader agree on one pattern.
package read_data_checker_pkg;

  localparam int DATA_W  = 64;
  localparam int COUNT_W = 25;
  localparam int INDEX_W = 24;

  localparam logic [DATA_W-1:0]  PATTERN_SEED = 64'hdeadfadebabebeef;
  localparam logic [COUNT_W-1:0] COUNT_MAX    = '1;

  typedef enum logic [1:0] {
    REASON_NONE     = 2'd0,
    REASON_MISMATCH = 2'd1,
    REASON_TIMEOUT  = 2'd2,
    REASON_SPURIOUS = 2'd3
  } fail_reason_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CHECKING  = 2'd1,
    ST_DONE_PASS = 2'd2,
    ST_DONE_FAIL = 2'd3
  } state_t;

  // Pattern word for a given index: seed XOR the zero-extended index.
  function automatic logic [DATA_W-1:0] expected_word(input logic [COUNT_W-1:0] index);
    return PATTERN_SEED ^ {{(DATA_W-COUNT_W){1'b0}}, index};
  endfunction

endpackage

// File: rtl/read_data_checker_if.sv
// Avalon read-data return bus from the DDR3 controller. The controller side
// drives it (master); the checker only observes it (slave). No backpressure.
interface read_data_checker_if;
  import read_data_checker_pkg::*;

  logic              avl_rdata_valid;
  logic [DATA_W-1:0] avl_rdata;

  modport master (output avl_rdata_valid, output avl_rdata);
  modport slave  (input  avl_rdata_valid, input  avl_rdata);

endinterface

// File: rtl/read_timeout_watchdog.sv
// Idle-gap watchdog for the read checker. Counts enabled cycles without a kick
// and flags expiry on the cycle that would make the idle count reach
// TIMEOUT_CYCLES, so the owner can register the verdict on that same edge.
// Only instantiated when READ_DATA_CHECKER_TIMEOUT_EN is defined.
module read_timeout_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] idle_count;

  assign expired = enable && !kick && (idle_count == LIMIT);

  // Idle counter: held at zero while disabled, restarted by every kick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_count <= '0;
    end else if (!enable || kick) begin
      idle_count <= '0;
    end else if (!expired) begin
      idle_count <= idle_count + 16'd1;
    end
  end

endmodule

// File: rtl/read_data_checker.sv
// read_data_checker: checks the in-order DDR3 read-data return stream against
// the shared test pattern and produces a sticky pass/fail verdict plus
// first-failure diagnostics. Optional idle watchdog: READ_DATA_CHECKER_TIMEOUT_EN.
module read_data_checker
  import read_data_checker_pkg::*;
#(
  parameter logic [COUNT_W-1:0] NUM_WORDS      = 25'h1000000,
  parameter int                 TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  read_data_checker_if.slave        avl,
  output logic                      is_finished,
  output logic                      pass,
  output logic                      fail,
  output fail_reason_t              fail_reason,
  output logic [COUNT_W-1:0]        words_checked,
  output logic [COUNT_W-1:0]        error_count,
  output logic [INDEX_W-1:0]        first_fail_index,
  output logic [DATA_W-1:0]         first_fail_data
);

  state_t             state;
  logic               accept;
  logic [COUNT_W-1:0] cur_index;
  logic [COUNT_W-1:0] base_errors;
  logic [COUNT_W-1:0] next_checked;
  logic [COUNT_W-1:0] next_errors;
  logic [DATA_W-1:0]  exp_word;
  logic               word_bad;
  logic               first_bad;
  logic               last_word;
  logic               timeout_expired;
  logic               wd_enable;

  assign wd_enable = (state == ST_CHECKING);

`ifdef READ_DATA_CHECKER_TIMEOUT_EN
  read_timeout_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .enable  (wd_enable),
    .kick    (avl.avl_rdata_valid),
    .expired (timeout_expired)
  );
`else
  // Without the watchdog the checker waits indefinitely for read data.
  logic timeout_unused;
  assign timeout_unused  = wd_enable && (TIMEOUT_CYCLES > 0);
  assign timeout_expired = 1'b0;
`endif

  // Word evaluation: an arm coinciding with a valid checks that word as index 0.
  always_comb begin
    accept       = avl.avl_rdata_valid &&
                   ((state == ST_CHECKING) || ((state == ST_IDLE) && arm));
    cur_index    = (state == ST_IDLE) ? '0 : {1'b0, words_checked[INDEX_W-1:0]};
    base_errors  = (state == ST_IDLE) ? '0 : error_count;
    exp_word     = expected_word(cur_index);
    word_bad     = (avl.avl_rdata != exp_word);
    first_bad    = word_bad && (base_errors == '0);
    next_checked = cur_index + COUNT_W'(1);
    next_errors  = base_errors;
    if (word_bad && (base_errors != COUNT_MAX)) begin
      next_errors = base_errors + COUNT_W'(1);
    end
    last_word    = (next_checked == NUM_WORDS);
  end

  // Checker FSM with registered verdict, counters and first-failure capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      is_finished      <= 1'b0;
      pass             <= 1'b0;
      fail             <= 1'b0;
      fail_reason      <= REASON_NONE;
      words_checked    <= '0;
      error_count      <= '0;
      first_fail_index <= '0;
      first_fail_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state            <= ST_CHECKING;
            words_checked    <= '0;
            error_count      <= '0;
            first_fail_index <= '0;
            first_fail_data  <= '0;
            fail_reason      <= REASON_NONE;
          end else if (avl.avl_rdata_valid) begin
            state       <= ST_DONE_FAIL;
            is_finished <= 1'b1;
            fail        <= 1'b1;
            fail_reason <= REASON_SPURIOUS;
          end
        end
        ST_CHECKING: begin
          if (!avl.avl_rdata_valid && timeout_expired) begin
            state       <= ST_DONE_FAIL;
            is_finished <= 1'b1;
            fail        <= 1'b1;
            if (fail_reason == REASON_NONE) begin
              fail_reason <= REASON_TIMEOUT;
            end
          end
        end
        ST_DONE_PASS: begin
          // Any data after a clean pass means the controller returned extra words.
          if (avl.avl_rdata_valid) begin
            state       <= ST_DONE_FAIL;
            pass        <= 1'b0;
            fail        <= 1'b1;
            fail_reason <= REASON_SPURIOUS;
          end
        end
        default: begin
        end
      endcase

      // Accepted words update counters; the final word also sets the verdict.
      if (accept) begin
        words_checked <= next_checked;
        error_count   <= next_errors;
        if (first_bad) begin
          first_fail_index <= cur_index[INDEX_W-1:0];
          first_fail_data  <= avl.avl_rdata;
          fail_reason      <= REASON_MISMATCH;
        end
        if (last_word) begin
          is_finished <= 1'b1;
          if (next_errors == '0) begin
            state <= ST_DONE_PASS;
            pass  <= 1'b1;
          end else begin
            state <= ST_DONE_FAIL;
            fail  <= 1'b1;
          end
        end
      end
    end
  end

endmodule
